// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag indices,
// FSM encoding and opcode classification helpers.
package alu_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b001010;
    localparam logic [5:0] OP_SUB = 6'b001011;
    localparam logic [5:0] OP_LSR = 6'b001100;
    localparam logic [5:0] OP_LSL = 6'b001101;
    localparam logic [5:0] OP_RSR = 6'b001110;
    localparam logic [5:0] OP_RSL = 6'b001111;
    localparam logic [5:0] OP_AND = 6'b010100;
    localparam logic [5:0] OP_OR  = 6'b010101;
    localparam logic [5:0] OP_XOR = 6'b010110;
    localparam logic [5:0] OP_NOT = 6'b010111;
    localparam logic [5:0] OP_CMP = 6'b011000;
    localparam logic [5:0] OP_TST = 6'b011001;
    localparam logic [5:0] OP_INC = 6'b011010;
    localparam logic [5:0] OP_DEC = 6'b011011;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RETIRE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // Which architectural registers an instruction updates when it retires.
    typedef enum logic [1:0] {
        WB_FULL  = 2'd0,
        WB_ACC   = 2'd1,
        WB_FLAGS = 2'd2,
        WB_NONE  = 2'd3
    } wb_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LSR, OP_LSL, OP_RSR, OP_RSL,
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CMP, OP_TST,
            OP_INC, OP_DEC: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic wb_e wb_kind(input logic move, input logic store,
                                    input logic [5:0] op);
        if (move)
            return WB_ACC;
        else if (store)
            return WB_NONE;
        else if (op == OP_CMP || op == OP_TST)
            return WB_FLAGS;
        else
            return WB_FULL;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller on the initiator side of the ALU interface: accepts one
// decoded instruction, drives the ALU, and retires rez/flags into acc/flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [WIDTH-1:0] in_val,
    input  logic             in_move,
    input  logic             in_store,
    output logic [5:0]       alu_op_code,
    output logic [WIDTH-1:0] alu_val,
    output logic [WIDTH-1:0] alu_reg0,
    output logic             alu_move,
    output logic             alu_store,
    input  logic             alu_ready,
    input  logic [3:0]       alu_flags,
    input  logic [WIDTH-1:0] alu_rez,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);

    state_e           state_q;
    wb_e              wb_q;
    logic             in_ready_q;
    logic [5:0]       alu_op_code_q;
    logic [WIDTH-1:0] alu_val_q;
    logic             alu_move_q;
    logic             alu_store_q;
    logic [WIDTH-1:0] acc_q;
    logic [3:0]       flags_q;
    logic             done_q;
    logic             err_q;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [WIDTH-1:0] rez_q;
    logic [3:0]       cflags_q;
    logic             capture;

    assign cnt_d   = cnt_q + 4'd1;
    assign capture = (state_q == ST_WAIT) && alu_ready;

    // Result capture is pure datapath; it is only consumed in RETIRE.
    always_ff @(posedge clk) begin
        if (capture) begin
            rez_q    <= alu_rez;
            cflags_q <= alu_flags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wb_q          <= WB_NONE;
            in_ready_q    <= 1'b0;
            alu_op_code_q <= OP_NOP;
            alu_val_q     <= '0;
            alu_move_q    <= 1'b0;
            alu_store_q   <= 1'b0;
            acc_q         <= '0;
            flags_q       <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        wb_q       <= wb_kind(in_move, in_store, in_op);
                        if (!in_move && !in_store && !is_legal_op(in_op)) begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            // ALU inputs become valid during ISSUE, ahead of its negedge sample.
                            state_q       <= ST_ISSUE;
                            alu_op_code_q <= in_op;
                            alu_val_q     <= in_val;
                            alu_move_q    <= in_move;
                            alu_store_q   <= in_store & ~in_move;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_ready) begin
                        state_q     <= ST_RETIRE;
                        done_q      <= 1'b1;
                        alu_move_q  <= 1'b0;
                        alu_store_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TO_LIMIT) begin
                            state_q       <= ST_ERROR;
                            err_q         <= 1'b1;
                            alu_op_code_q <= OP_NOP;
                            alu_move_q    <= 1'b0;
                            alu_store_q   <= 1'b0;
                        end
                    end
                end
                ST_RETIRE: begin
                    case (wb_q)
                        WB_FULL: begin
                            acc_q   <= rez_q;
                            flags_q <= cflags_q;
                        end
                        WB_ACC:   acc_q   <= rez_q;
                        WB_FLAGS: flags_q <= cflags_q;
                        WB_NONE:  ;
                    endcase
                    alu_op_code_q <= OP_NOP;
                    in_ready_q    <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                ST_ERROR: begin
                    alu_op_code_q <= OP_NOP;
                    alu_move_q    <= 1'b0;
                    alu_store_q   <= 1'b0;
                    in_ready_q    <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign alu_op_code = alu_op_code_q;
    assign alu_val     = alu_val_q;
    assign alu_reg0    = acc_q;
    assign alu_move    = alu_move_q;
    assign alu_store   = alu_store_q;
    assign acc         = acc_q;
    assign flags       = flags_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small negedge ALU responder that
// can be stalled to provoke the timeout path.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   in_op = '0;
    logic [W-1:0] in_val = '0;
    logic         in_move = 1'b0;
    logic         in_store = 1'b0;
    logic [5:0]   alu_op_code;
    logic [W-1:0] alu_val;
    logic [W-1:0] alu_reg0;
    logic         alu_move;
    logic         alu_store;
    logic         alu_ready = 1'b0;
    logic [3:0]   alu_flags = '0;
    logic [W-1:0] alu_rez = '0;
    logic [W-1:0] acc;
    logic [3:0]   flags;
    logic         done;
    logic         err;

    int  n_checks = 0;
    int  n_fail = 0;
    int  n_done = 0;
    int  n_err = 0;
    int  cyc = 0;
    logic stall = 1'b0;

    alu_issue_ctrl #(.WIDTH(W), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_val(in_val),
        .in_move(in_move), .in_store(in_store),
        .alu_op_code(alu_op_code), .alu_val(alu_val), .alu_reg0(alu_reg0),
        .alu_move(alu_move), .alu_store(alu_store), .alu_ready(alu_ready),
        .alu_flags(alu_flags), .alu_rez(alu_rez),
        .acc(acc), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (err)  n_err  <= n_err + 1;
    end

    // Responder ALU: evaluates on negedge, answers immediately unless stalled.
    always @(negedge clk) begin
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        t = '0; c = 1'b0; v = 1'b0;
        if (alu_move)
            r = alu_val;
        else if (alu_store)
            r = alu_reg0;
        else begin
            case (alu_op_code)
                OP_ADD: begin
                    t = {1'b0, alu_reg0} + {1'b0, alu_val};
                    r = t[W-1:0]; c = t[W];
                    v = (alu_reg0[W-1] == alu_val[W-1]) && (r[W-1] != alu_reg0[W-1]);
                end
                OP_SUB, OP_CMP: begin
                    t = {1'b0, alu_reg0} - {1'b0, alu_val};
                    r = t[W-1:0]; c = t[W];
                    v = (alu_reg0[W-1] != alu_val[W-1]) && (r[W-1] != alu_reg0[W-1]);
                end
                OP_INC:         r = alu_reg0 + 1;
                OP_DEC:         r = alu_reg0 - 1;
                OP_LSL:         r = alu_reg0 << alu_val;
                OP_LSR:         r = alu_reg0 >> alu_val;
                OP_AND, OP_TST: r = alu_reg0 & alu_val;
                OP_OR:          r = alu_reg0 | alu_val;
                OP_XOR:         r = alu_reg0 ^ alu_val;
                OP_NOT:         r = ~alu_reg0;
                default:        r = '0;
            endcase
        end
        alu_rez   <= r;
        alu_flags <= {v, c, r[W-1], (r == '0)};
        alu_ready <= !stall && (alu_move || alu_store || (alu_op_code != OP_NOP));
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 20);
        if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic mv, input logic st, input logic [5:0] op, input logic [W-1:0] v);
        wait_ready();
        in_move = mv; in_store = st; in_op = op; in_val = v; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic mv, input logic st, input logic [5:0] op,
                          input logic [W-1:0] v, input logic [W-1:0] ea, input logic [3:0] ef);
        send(mv, st, op, v);
        @(negedge clk); check_eq({tag, "_c1"}, {30'd0, done, err}, 32'd0);
        @(negedge clk); check_eq({tag, "_c2"}, {30'd0, done, err}, 32'd0);
        @(negedge clk); check_eq({tag, "_done"}, {30'd0, done, err}, 32'd2);
        @(negedge clk);
        check_eq({tag, "_acc"}, acc, ea);
        check_eq({tag, "_flags"}, 32'(flags), 32'(ef));
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int done_snap;
        int err_snap;
        int k;
        int guard;
        int acc_cyc [3];
        logic [5:0]   b_op [3];
        logic         b_mv [3];
        logic [W-1:0] b_val [3];

        #1;
        check_eq("rst_acc", acc, 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_pulses", {30'd0, done, err}, 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_alu", {alu_op_code, alu_move, alu_store}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1 check_eq("rel_ready_lo", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 check_eq("rel_ready_hi", 32'(in_ready), 32'd1);

        run_op("move5", 1'b1, 1'b0, OP_NOP, 32'd5, 32'd5, 4'b0000);
        run_op("add3",  1'b0, 1'b0, OP_ADD, 32'd3, 32'd8, 4'b0000);
        run_op("move7", 1'b1, 1'b0, OP_NOP, 32'd7, 32'd7, 4'b0000);
        run_op("cmp7",  1'b0, 1'b0, OP_CMP, 32'd7, 32'd7, 4'b0001);
        check_eq("cmp_z", 32'(flags[FLAG_Z]), 32'd1);

        send(1'b0, 1'b0, 6'b000001, 32'd99);
        @(negedge clk);
        check_eq("ill_err", {30'd0, done, err}, 32'd1);
        check_eq("ill_op", 32'(alu_op_code), 32'd0);
        @(negedge clk);
        check_eq("ill_err_off", 32'(err), 32'd0);
        check_eq("ill_ready", 32'(in_ready), 32'd1);
        check_eq("ill_acc", acc, 32'd7);
        check_eq("ill_flags", 32'(flags), 32'd1);

        run_op("store", 1'b0, 1'b1, OP_ADD, 32'd100, 32'd7, 4'b0001);
        run_op("sub8",  1'b0, 1'b0, OP_SUB, 32'd8, 32'hFFFF_FFFF, 4'b0110);
        run_op("mvst9", 1'b1, 1'b1, OP_NOP, 32'd9, 32'd9, 4'b0110);

        stall = 1'b1;
        send(1'b0, 1'b0, OP_ADD, 32'd1);
        done_snap = n_done;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("to_err_c%0d", i), 32'(err), (i == 6) ? 32'd1 : 32'd0);
        end
        check_eq("to_op", 32'(alu_op_code), 32'd0);
        @(negedge clk);
        #1;
        check_eq("to_acc", acc, 32'd9);
        check_eq("to_ready", 32'(in_ready), 32'd1);
        check_eq("to_nodone", 32'(n_done - done_snap), 32'd0);
        stall = 1'b0;

        b_mv[0] = 1'b1; b_op[0] = OP_NOP; b_val[0] = 32'd1;
        b_mv[1] = 1'b0; b_op[1] = OP_INC; b_val[1] = 32'd0;
        b_mv[2] = 1'b0; b_op[2] = OP_LSL; b_val[2] = 32'd4;
        in_move = b_mv[0]; in_store = 1'b0; in_op = b_op[0]; in_val = b_val[0]; in_valid = 1'b1;
        k = 0; guard = 0;
        while (k < 3 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                acc_cyc[k] = cyc;
                @(posedge clk);
                #1;
                k++;
                if (k < 3) begin
                    in_move = b_mv[k]; in_op = b_op[k]; in_val = b_val[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check_eq("b2b_count", 32'(k), 32'd3);
        if (k == 3) begin
            check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        end
        repeat (4) @(negedge clk);
        check_eq("b2b_acc", acc, 32'd32);
        check_eq("b2b_flags", 32'(flags), 32'd0);

        stall = 1'b1;
        send(1'b0, 1'b0, OP_ADD, 32'd1);
        @(negedge clk);
        @(negedge clk);
        done_snap = n_done;
        err_snap = n_err;
        reset_n = 1'b0;
        #1;
        check_eq("mr_acc", acc, 32'd0);
        check_eq("mr_flags", 32'(flags), 32'd0);
        check_eq("mr_alu", {alu_op_code, alu_move, alu_store}, 32'd0);
        check_eq("mr_val", alu_val, 32'd0);
        check_eq("mr_ready", 32'(in_ready), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_eq("mr_ready_hi", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        #1;
        check_eq("mr_nodone", 32'(n_done - done_snap), 32'd0);
        check_eq("mr_noerr", 32'(n_err - err_snap), 32'd0);
        check_eq("mr_acc_hold", acc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench timed out");
    end

endmodule
